irq_ctrl: RTL and testbench
===========================

IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 3, number of external interrupt sources.
REQ-002 SHALL have parameter BASE_BIT, default 5, cpu_irq bit driven by source 0 (source i -> bit BASE_BIT+i).
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0300_0000, register window base; hit when mem_addr[31:8]==BASE_ADDR[31:8].
REQ-004 clk  in  1  single system clock, all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 irq_in  in  NUM_IRQ  raw asynchronous interrupt pins (board irq_5..irq_7); bit 0 highest priority.
REQ-007 mem_valid  in  1  CPU native-bus request.
REQ-008 mem_addr  in  32  byte address.
REQ-009 mem_wdata  in  32  write data.
REQ-010 mem_wstrb  in  4  byte strobes; 0 = read.
REQ-011 mem_rdata  out  32  read data, valid with mem_ready.
REQ-012 mem_ready  out  1  one-cycle acknowledge.
REQ-013 cpu_irq  out  32  interrupt vector to CPU; only bits BASE_BIT..BASE_BIT+NUM_IRQ-1 ever set.
REQ-014 cpu_eoi  in  32  CPU in-service vector.

Function
REQ-015 Each irq_in bit SHALL pass a 2-flop synchronizer; edge detect uses a third flop (rising edge = sync & ~prev).
REQ-016 Registers (offset, access): 0x00 PENDING RO/W1C, 0x04 MASK RW (1=enabled), 0x08 EDGE RW (1=rising-edge, 0=level), 0x0C STATUS RO {state[1:0] in [9:8], active id in [3:0]}; other offsets read 0, writes ignored.
REQ-017 Bus: hit with mem_valid SHALL give mem_ready high exactly one cycle, registered, one cycle after request; no second ready while mem_valid stays high in that ready cycle; writes apply when mem_ready asserts; non-hits never assert mem_ready.
REQ-018 Only mem_wstrb[0] SHALL qualify writes (registers are NUM_IRQ bits wide, zero-extended on read).
REQ-019 Edge source: pending bit sets on rising edge; clears by W1C or on in-service entry; set wins over simultaneous clear.
REQ-020 Level source: pending bit equals synchronized level; W1C has no effect.
REQ-021 Eligible = PENDING & MASK; winner = lowest eligible index.
REQ-022 FSM IDLE: if eligible nonzero, latch winner id, go ASSERT.
REQ-023 ASSERT: drive cpu_irq[BASE_BIT+id]=1; if source masked or (level and pending drops) before EOI, retract to IDLE next cycle; on cpu_eoi[BASE_BIT+id]=1 go SERVICE, clear edge pending.
REQ-024 SERVICE: cpu_irq all zero; stay until cpu_eoi[BASE_BIT+id]=0, then IDLE; mask changes ignored.
REQ-025 Higher-priority arrivals during ASSERT/SERVICE SHALL NOT preempt; served after return to IDLE.
REQ-026 cpu_irq SHALL be registered; at most one bit set at any time.

Reset
REQ-027 On reset: synchronizers 0, PENDING 0, MASK 0, EDGE all 1, FSM IDLE, id 0, cpu_irq 0, mem_ready 0, mem_rdata 0.
REQ-028 Reset asserted mid-ASSERT or mid-SERVICE SHALL drop cpu_irq in the same cycle asynchronously; no pending survives.

Structure
REQ-029 Register offsets and FSM state encodings (IDLE=0, ASSERT=1, SERVICE=2) SHALL live in shared package/include irq_ctrl_defs.
REQ-030 Synchronizer + edge detect SHALL be a sub-module irq_sync, instantiated per source.

Verification
REQ-031 MASK=7, pulse irq_in[0] 40 cycles -> cpu_irq[5]=1 within 5 cycles; drive cpu_eoi[5]=1 -> cpu_irq=0, PENDING=0; eoi low -> STATUS state 0.
REQ-032 Edges on irq_in[2] and irq_in[1] same cycle, MASK=7 -> cpu_irq[6] first; after EOI cycle completes -> cpu_irq[7].
REQ-033 MASK=0, edge on irq_in[1] -> PENDING=2, cpu_irq=0; write MASK=2 -> cpu_irq[6]=1; write MASK=0 before EOI -> cpu_irq retracts, PENDING still 2.
REQ-034 EDGE=0, MASK=4, hold irq_in[2] high -> cpu_irq[7]; W1C PENDING=4 -> PENDING reads 4; release before EOI -> retract.
REQ-035 Read 0x04 after write 0x05 -> mem_rdata=5, mem_ready one cycle; read 0x20 -> 0; mem_addr=0x0400_0000 -> no mem_ready.
REQ-036 Reset asserted in SERVICE -> cpu_irq=0 immediately, all registers reset values per REQ-027.

Source files
------------

// File: rtl/irq_ctrl_defs.sv
// Shared definitions for the interrupt controller: register offsets and FSM encodings.
package irq_ctrl_defs;

   localparam logic [7:0] OFF_PENDING = 8'h00;
   localparam logic [7:0] OFF_MASK    = 8'h04;
   localparam logic [7:0] OFF_EDGE    = 8'h08;
   localparam logic [7:0] OFF_STATUS  = 8'h0C;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ASSERT  = 2'd1,
      ST_SERVICE = 2'd2
   } irq_state_e;

endpackage

// File: rtl/irq_ctrl_if.sv
// CPU native memory bus as seen by the interrupt controller register window.
interface irq_ctrl_if;
   logic        mem_valid;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata;
   logic        mem_ready;

   modport master (
      output mem_valid, mem_addr, mem_wdata, mem_wstrb,
      input  mem_rdata, mem_ready
   );

   modport slave (
      input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
      output mem_rdata, mem_ready
   );
endinterface

// File: rtl/irq_ctrl_regs.sv
// Register window of the interrupt controller: bus decode, PENDING/MASK/EDGE storage, read mux.
module irq_ctrl_regs
   import irq_ctrl_defs::*;
#(
   parameter int          NUM_IRQ   = 3,
   parameter logic [31:0] BASE_ADDR = 32'h0300_0000
) (
   input  logic               clk,
   input  logic               reset,
   irq_ctrl_if.slave          bus,
   input  logic [NUM_IRQ-1:0] src_level,
   input  logic [NUM_IRQ-1:0] src_rise,
   input  logic [NUM_IRQ-1:0] svc_clr,
   input  irq_state_e         state,
   input  logic [3:0]         active_id,
   output logic [NUM_IRQ-1:0] pending,
   output logic [NUM_IRQ-1:0] mask,
   output logic [NUM_IRQ-1:0] edge_mode
);

   logic [NUM_IRQ-1:0] edge_pend;
   logic [NUM_IRQ-1:0] w1c;
   logic [7:0]         offset;
   logic [31:0]        rd_data;
   logic               hit;
   logic               ack;
   logic               wr_en;
   logic               unused_bus;

   assign offset = bus.mem_addr[7:0];
   assign hit    = bus.mem_valid && (bus.mem_addr[31:8] == BASE_ADDR[31:8]);
   // Ready is blocked in its own cycle so a CPU still holding valid is not acked twice.
   assign ack    = hit && !bus.mem_ready;
   assign wr_en  = ack && bus.mem_wstrb[0];
   assign w1c    = (wr_en && offset == OFF_PENDING) ? bus.mem_wdata[NUM_IRQ-1:0] : '0;

   assign pending    = (edge_mode & edge_pend) | (~edge_mode & src_level);
   assign unused_bus = ^{bus.mem_wdata[31:NUM_IRQ], bus.mem_wstrb[3:1]};

   always_comb begin
      rd_data = '0;
      case (offset)
         OFF_PENDING: rd_data[NUM_IRQ-1:0] = pending;
         OFF_MASK:    rd_data[NUM_IRQ-1:0] = mask;
         OFF_EDGE:    rd_data[NUM_IRQ-1:0] = edge_mode;
         OFF_STATUS: begin
            rd_data[9:8] = state;
            rd_data[3:0] = active_id;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mask          <= '0;
         edge_mode     <= '1;
         edge_pend     <= '0;
         bus.mem_ready <= 1'b0;
         bus.mem_rdata <= '0;
      end else begin
         bus.mem_ready <= ack;
         bus.mem_rdata <= ack ? rd_data : '0;
         // A new edge wins over a same-cycle W1C or service clear; level sources keep this at 0.
         edge_pend <= edge_mode & (src_rise | (edge_pend & ~(w1c | svc_clr)));
         if (wr_en && offset == OFF_MASK)
            mask <= bus.mem_wdata[NUM_IRQ-1:0];
         if (wr_en && offset == OFF_EDGE)
            edge_mode <= bus.mem_wdata[NUM_IRQ-1:0];
      end
   end

endmodule

// File: rtl/irq_sync.sv
// Two-flop synchronizer for one raw interrupt pin plus a third flop for rising-edge detect.
module irq_sync (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic level,
   output logic rise
);

   logic meta;
   logic sync;
   logic prev;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta <= 1'b0;
         sync <= 1'b0;
         prev <= 1'b0;
      end else begin
         meta <= din;
         sync <= meta;
         prev <= sync;
      end
   end

   assign level = sync;
   assign rise  = sync & ~prev;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller top: per-pin synchronizers, register window and the assert/service FSM.
//   state      | meaning
//   ST_IDLE    | no vector driven, waiting for an eligible source
//   ST_ASSERT  | cpu_irq bit of latched source driven, waiting for EOI or retract
//   ST_SERVICE | CPU servicing latched source, waiting for its EOI to drop
module irq_ctrl
   import irq_ctrl_defs::*;
#(
   parameter int          NUM_IRQ   = 3,
   parameter int          BASE_BIT  = 5,
   parameter logic [31:0] BASE_ADDR = 32'h0300_0000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_IRQ-1:0] irq_in,
   irq_ctrl_if.slave          bus,
   output logic [31:0]        cpu_irq,
   input  logic [31:0]        cpu_eoi
);

   irq_state_e         state_q;
   irq_state_e         state_n;
   logic [NUM_IRQ-1:0] sel_q;
   logic [NUM_IRQ-1:0] sel_n;
   logic [NUM_IRQ-1:0] src_level;
   logic [NUM_IRQ-1:0] src_rise;
   logic [NUM_IRQ-1:0] src_eoi;
   logic [NUM_IRQ-1:0] pending;
   logic [NUM_IRQ-1:0] mask;
   logic [NUM_IRQ-1:0] edge_mode;
   logic [NUM_IRQ-1:0] eligible;
   logic [NUM_IRQ-1:0] winner;
   logic [NUM_IRQ-1:0] svc_clr;
   logic [3:0]         active_id;
   logic [31:0]        irq_n;
   logic               eoi_hit;
   logic               retract;
   logic               unused_eoi;

   for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
      irq_sync u_sync (
         .clk   (clk),
         .reset (reset),
         .din   (irq_in[g]),
         .level (src_level[g]),
         .rise  (src_rise[g])
      );
   end

   irq_ctrl_regs #(
      .NUM_IRQ   (NUM_IRQ),
      .BASE_ADDR (BASE_ADDR)
   ) u_regs (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .src_level (src_level),
      .src_rise  (src_rise),
      .svc_clr   (svc_clr),
      .state     (state_q),
      .active_id (active_id),
      .pending   (pending),
      .mask      (mask),
      .edge_mode (edge_mode)
   );

   assign src_eoi    = cpu_eoi[BASE_BIT +: NUM_IRQ];
   assign unused_eoi = ^cpu_eoi;
   assign eligible   = pending & mask;
   assign eoi_hit    = |(sel_q & src_eoi);
   assign retract    = (|(sel_q & ~mask)) || (|(sel_q & ~edge_mode & ~pending));

   always_comb begin
      winner = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            winner    = '0;
            winner[i] = 1'b1;
         end
      end
   end

   always_comb begin
      active_id = '0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         if (sel_q[i])
            active_id = 4'(i);
      end
   end

   always_comb begin
      state_n = state_q;
      sel_n   = sel_q;
      svc_clr = '0;
      case (state_q)
         ST_IDLE: begin
            if (|eligible) begin
               sel_n   = winner;
               state_n = ST_ASSERT;
            end
         end
         ST_ASSERT: begin
            if (eoi_hit) begin
               state_n = ST_SERVICE;
               svc_clr = sel_q;
            end else if (retract) begin
               state_n = ST_IDLE;
            end
         end
         ST_SERVICE: begin
            if (!eoi_hit)
               state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_comb begin
      irq_n = '0;
      if (state_n == ST_ASSERT)
         irq_n[BASE_BIT +: NUM_IRQ] = sel_n;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         sel_q   <= '0;
         cpu_irq <= '0;
      end else begin
         state_q <= state_n;
         sel_q   <= sel_n;
         cpu_irq <= irq_n;
      end
   end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl: reset, priority, masking, level/edge modes and bus timing.
module tb_irq_ctrl;
   import irq_ctrl_defs::*;

   localparam logic [31:0] BASE = 32'h0300_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [2:0]  irq_in;
   logic [31:0] cpu_irq;
   logic [31:0] cpu_eoi;
   logic [31:0] r;
   int          n;
   int          checks = 0;
   int          failures = 0;

   irq_ctrl_if bus ();

   irq_ctrl dut (
      .clk     (clk),
      .reset   (reset),
      .irq_in  (irq_in),
      .bus     (bus),
      .cpu_irq (cpu_irq),
      .cpu_eoi (cpu_eoi)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int cnt);
      repeat (cnt) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic access(input logic [7:0] off, input logic [31:0] wd, input logic [3:0] strb,
                         output logic [31:0] rd);
      bit got = 1'b0;
      rd = 'x;
      bus.mem_valid = 1'b1;
      bus.mem_addr  = BASE | 32'(off);
      bus.mem_wdata = wd;
      bus.mem_wstrb = strb;
      for (int i = 0; i < 4 && !got; i++) begin
         tick(1);
         if (bus.mem_ready === 1'b1) begin
            got = 1'b1;
            rd  = bus.mem_rdata;
         end
      end
      bus.mem_valid = 1'b0;
      bus.mem_wstrb = 4'h0;
      check("bus_ready", 32'(got), 32'd1);
      tick(1);
   endtask

   task automatic wr(input logic [7:0] off, input logic [31:0] wd);
      logic [31:0] dummy;
      access(off, wd, 4'hF, dummy);
   endtask

   task automatic rd_chk(input logic [7:0] off, input logic [31:0] exp, input string tag);
      logic [31:0] v;
      access(off, 32'h0, 4'h0, v);
      check(tag, v, exp);
   endtask

   task automatic wait_irq(input logic [31:0] exp, input int bound, input string tag);
      for (int i = 0; i < bound && cpu_irq !== exp; i++)
         tick(1);
      check(tag, cpu_irq, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      irq_in        = '0;
      cpu_eoi       = '0;
      bus.mem_valid = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.mem_wstrb = '0;
      tick(3);
      check("rst_cpu_irq", cpu_irq, 32'h0);
      check("rst_ready", 32'(bus.mem_ready), 32'h0);
      check("rst_rdata", bus.mem_rdata, 32'h0);
      reset = 1'b0;
      tick(1);
      rd_chk(OFF_PENDING, 32'h0, "rst_pending");
      rd_chk(OFF_MASK,    32'h0, "rst_mask");
      rd_chk(OFF_EDGE,    32'h7, "rst_edge");
      rd_chk(OFF_STATUS,  32'h0, "rst_status");

      // single edge source through assert, service and back to idle
      wr(OFF_MASK, 32'h7);
      irq_in = 3'b001;
      wait_irq(32'h20, 5, "s1_irq5");
      rd_chk(OFF_STATUS, 32'h100, "s1_status_assert");
      tick(30);
      irq_in = 3'b000;
      check("s1_hold", cpu_irq, 32'h20);
      cpu_eoi = 32'h20;
      tick(1);
      check("s1_service_irq", cpu_irq, 32'h0);
      rd_chk(OFF_PENDING, 32'h0, "s1_pending");
      rd_chk(OFF_STATUS, 32'h200, "s1_status_service");
      cpu_eoi = 32'h0;
      tick(1);
      rd_chk(OFF_STATUS, 32'h0, "s1_status_idle");

      // simultaneous edges: lower index first, the other after EOI completes
      irq_in = 3'b110;
      wait_irq(32'h40, 6, "s2_first");
      irq_in = 3'b000;
      rd_chk(OFF_PENDING, 32'h6, "s2_pending");
      cpu_eoi = 32'h40;
      tick(1);
      check("s2_service", cpu_irq, 32'h0);
      cpu_eoi = 32'h0;
      wait_irq(32'h80, 4, "s2_second");
      cpu_eoi = 32'h80;
      tick(1);
      cpu_eoi = 32'h0;
      tick(2);
      check("s2_done", cpu_irq, 32'h0);
      rd_chk(OFF_PENDING, 32'h0, "s2_pending_clr");

      // masked pending, unmask asserts, re-mask retracts
      wr(OFF_MASK, 32'h0);
      irq_in = 3'b010;
      tick(4);
      irq_in = 3'b000;
      tick(3);
      rd_chk(OFF_PENDING, 32'h2, "s3_pending");
      check("s3_masked", cpu_irq, 32'h0);
      wr(OFF_MASK, 32'h2);
      wait_irq(32'h40, 4, "s3_unmask");
      wr(OFF_MASK, 32'h0);
      wait_irq(32'h0, 3, "s3_retract");
      rd_chk(OFF_PENDING, 32'h2, "s3_pending_kept");
      wr(OFF_PENDING, 32'h2);
      rd_chk(OFF_PENDING, 32'h0, "s3_w1c");

      // level source: W1C has no effect, release retracts
      wr(OFF_EDGE, 32'h0);
      wr(OFF_MASK, 32'h4);
      irq_in = 3'b100;
      wait_irq(32'h80, 5, "s4_level");
      wr(OFF_PENDING, 32'h4);
      rd_chk(OFF_PENDING, 32'h4, "s4_w1c_ignored");
      check("s4_still", cpu_irq, 32'h80);
      irq_in = 3'b000;
      wait_irq(32'h0, 5, "s4_release");
      rd_chk(OFF_PENDING, 32'h0, "s4_pending");
      wr(OFF_EDGE, 32'h7);

      // bus timing and decode
      wr(OFF_MASK, 32'h5);
      bus.mem_valid = 1'b1;
      bus.mem_addr  = BASE | 32'h4;
      bus.mem_wstrb = 4'h0;
      check("s5_ready_pre", 32'(bus.mem_ready), 32'h0);
      tick(1);
      check("s5_ready", 32'(bus.mem_ready), 32'h1);
      check("s5_rdata", bus.mem_rdata, 32'h5);
      tick(1);
      check("s5_single", 32'(bus.mem_ready), 32'h0);
      bus.mem_valid = 1'b0;
      tick(1);
      rd_chk(8'h20, 32'h0, "s5_reserved");
      access(OFF_MASK, 32'h2, 4'b0010, r);
      rd_chk(OFF_MASK, 32'h5, "s5_strobe");
      wr(8'h10, 32'h7);
      rd_chk(OFF_MASK, 32'h5, "s5_reserved_wr");
      bus.mem_valid = 1'b1;
      bus.mem_addr  = 32'h0400_0000;
      n = 0;
      repeat (4) begin
         tick(1);
         if (bus.mem_ready === 1'b1) n++;
      end
      bus.mem_valid = 1'b0;
      check("s5_miss", 32'(n), 32'h0);

      // reset during service with another source pending
      wr(OFF_MASK, 32'h7);
      irq_in = 3'b001;
      wait_irq(32'h20, 5, "s6_assert");
      irq_in = 3'b000;
      cpu_eoi = 32'h20;
      tick(1);
      check("s6_service", cpu_irq, 32'h0);
      irq_in = 3'b010;
      tick(4);
      irq_in = 3'b000;
      rd_chk(OFF_STATUS, 32'h200, "s6_no_preempt");
      rd_chk(OFF_PENDING, 32'h2, "s6_pending");
      reset = 1'b1;
      #1;
      check("s6_rst_irq", cpu_irq, 32'h0);
      tick(1);
      cpu_eoi = 32'h0;
      reset = 1'b0;
      tick(1);
      rd_chk(OFF_PENDING, 32'h0, "s6_rst_pending");
      rd_chk(OFF_MASK,    32'h0, "s6_rst_mask");
      rd_chk(OFF_EDGE,    32'h7, "s6_rst_edge");
      rd_chk(OFF_STATUS,  32'h0, "s6_rst_status");

      // reset mid-assert drops cpu_irq without waiting for a clock edge
      wr(OFF_MASK, 32'h7);
      irq_in = 3'b100;
      wait_irq(32'h80, 5, "s7_assert");
      #2;
      reset = 1'b1;
      #1;
      check("s7_async_drop", cpu_irq, 32'h0);
      irq_in = 3'b000;
      tick(1);
      reset = 1'b0;
      tick(1);
      rd_chk(OFF_PENDING, 32'h0, "s7_pending");
      check("s7_idle", cpu_irq, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
